// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared CPU memory-system types and widths
package params_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int CACHE_LINE_BYTES = 16;

  typedef enum logic [1:0] {
    SIZE_BYTE,
    SIZE_HALF,
    SIZE_WORD,
    SIZE_LINE
  } access_size_t;

  // Which transaction currently owns the shared memory port
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IC_RD,
    ARB_DC_RD,
    ARB_DC_WR
  } arb_state_t;

  // Round-robin memory of the most recent grant
  typedef enum logic {
    ARB_OWNER_IC,
    ARB_OWNER_DC
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin icache/dcache arbiter onto the shared memory port
module mem_port_arbiter
  import params_pkg::*;
#(
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int LINE_WIDTH = params_pkg::CACHE_LINE_BYTES * 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ic_rd_req_i,
  input  logic [ADDR_WIDTH-1:0] ic_addr_i,
  input  access_size_t          ic_access_size_i,
  output logic                  ic_data_valid_o,
  output logic [LINE_WIDTH-1:0] ic_data_o,
  input  logic                  dc_rd_req_i,
  input  logic                  dc_wr_req_i,
  input  logic [ADDR_WIDTH-1:0] dc_addr_i,
  input  logic [LINE_WIDTH-1:0] dc_wr_data_i,
  input  access_size_t          dc_access_size_i,
  output logic                  dc_data_valid_o,
  output logic [LINE_WIDTH-1:0] dc_data_o,
  output logic                  dc_wr_done_o,
  output logic                  rd_req_valid_o,
  output logic                  wr_req_valid_o,
  output logic                  req_is_instr_o,
  output logic [ADDR_WIDTH-1:0] req_address_o,
  output logic [LINE_WIDTH-1:0] wr_data_o,
  output access_size_t          req_access_size_o,
  input  logic                  mem_data_valid_i,
  input  logic                  mem_data_is_instr_i,
  input  logic                  mem_write_done_i,
  input  logic [LINE_WIDTH-1:0] mem_data_i,
  output logic                  busy_o,
  output logic                  err_o
);

  arb_state_t            state_q;
  arb_owner_t            last_grant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  access_size_t          size_q;
  logic [LINE_WIDTH-1:0] wr_data_q;
  logic                  is_instr_q;
  logic                  err_q;

  logic                  grant_d;
  arb_owner_t            owner_d;
  logic                  dc_cand;

  // Round-robin pick: on contention, grant the cache that did not win last time
  always_comb begin
    grant_d = 1'b0;
    owner_d = ARB_OWNER_IC;
    dc_cand = dc_wr_req_i | dc_rd_req_i;
    if (ic_rd_req_i && dc_cand) begin
      grant_d = 1'b1;
      owner_d = (last_grant_q == ARB_OWNER_IC) ? ARB_OWNER_DC : ARB_OWNER_IC;
    end else if (ic_rd_req_i) begin
      grant_d = 1'b1;
      owner_d = ARB_OWNER_IC;
    end else if (dc_cand) begin
      grant_d = 1'b1;
      owner_d = ARB_OWNER_DC;
    end
  end

  // Transaction FSM: latch a granted request, hold it until the matching response
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ARB_OWNER_IC;
      addr_q       <= '0;
      size_q       <= SIZE_BYTE;
      wr_data_q    <= '0;
      is_instr_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          // Nothing is outstanding, so any response here is dropped
          if (mem_data_valid_i || mem_write_done_i) begin
            err_q <= 1'b1;
          end
          if (grant_d) begin
            last_grant_q <= owner_d;
            if (owner_d == ARB_OWNER_IC) begin
              addr_q     <= ic_addr_i;
              size_q     <= ic_access_size_i;
              is_instr_q <= 1'b1;
              state_q    <= ARB_IC_RD;
            end else begin
              addr_q     <= dc_addr_i;
              size_q     <= dc_access_size_i;
              is_instr_q <= 1'b0;
              if (dc_wr_req_i) begin
                wr_data_q <= dc_wr_data_i;
                state_q   <= ARB_DC_WR;
              end else begin
                state_q   <= ARB_DC_RD;
              end
            end
          end
        end
        ARB_IC_RD, ARB_DC_RD: begin
          if (mem_write_done_i) begin
            err_q <= 1'b1;
          end
          if (mem_data_valid_i) begin
            if (mem_data_is_instr_i != is_instr_q) begin
              err_q <= 1'b1;
            end
            state_q <= ARB_IDLE;
          end
        end
        ARB_DC_WR: begin
          if (mem_data_valid_i) begin
            err_q <= 1'b1;
          end
          if (mem_write_done_i) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign busy_o            = (state_q != ARB_IDLE);
  assign err_o             = err_q;
  assign rd_req_valid_o    = (state_q == ARB_IC_RD) || (state_q == ARB_DC_RD);
  assign wr_req_valid_o    = (state_q == ARB_DC_WR);
  assign req_is_instr_o    = is_instr_q;
  assign req_address_o     = addr_q;
  assign req_access_size_o = size_q;
  assign wr_data_o         = wr_data_q;

  assign ic_data_valid_o   = mem_data_valid_i & (state_q == ARB_IC_RD);
  assign dc_data_valid_o   = mem_data_valid_i & (state_q == ARB_DC_RD);
  assign dc_wr_done_o      = mem_write_done_i & (state_q == ARB_DC_WR);
  assign ic_data_o         = mem_data_i;
  assign dc_data_o         = mem_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized model-based bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import params_pkg::*;

  localparam int AW = params_pkg::ADDR_WIDTH;
  localparam int LW = params_pkg::CACHE_LINE_BYTES * 8;

  logic          clk_i;
  logic          rst_i;
  logic          ic_rd_req_i;
  logic [AW-1:0] ic_addr_i;
  access_size_t  ic_access_size_i;
  logic          ic_data_valid_o;
  logic [LW-1:0] ic_data_o;
  logic          dc_rd_req_i;
  logic          dc_wr_req_i;
  logic [AW-1:0] dc_addr_i;
  logic [LW-1:0] dc_wr_data_i;
  access_size_t  dc_access_size_i;
  logic          dc_data_valid_o;
  logic [LW-1:0] dc_data_o;
  logic          dc_wr_done_o;
  logic          rd_req_valid_o;
  logic          wr_req_valid_o;
  logic          req_is_instr_o;
  logic [AW-1:0] req_address_o;
  logic [LW-1:0] wr_data_o;
  access_size_t  req_access_size_o;
  logic          mem_data_valid_i;
  logic          mem_data_is_instr_i;
  logic          mem_write_done_i;
  logic [LW-1:0] mem_data_i;
  logic          busy_o;
  logic          err_o;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ic_rd_req_i(ic_rd_req_i), .ic_addr_i(ic_addr_i), .ic_access_size_i(ic_access_size_i),
    .ic_data_valid_o(ic_data_valid_o), .ic_data_o(ic_data_o),
    .dc_rd_req_i(dc_rd_req_i), .dc_wr_req_i(dc_wr_req_i), .dc_addr_i(dc_addr_i),
    .dc_wr_data_i(dc_wr_data_i), .dc_access_size_i(dc_access_size_i),
    .dc_data_valid_o(dc_data_valid_o), .dc_data_o(dc_data_o), .dc_wr_done_o(dc_wr_done_o),
    .rd_req_valid_o(rd_req_valid_o), .wr_req_valid_o(wr_req_valid_o),
    .req_is_instr_o(req_is_instr_o), .req_address_o(req_address_o), .wr_data_o(wr_data_o),
    .req_access_size_o(req_access_size_o),
    .mem_data_valid_i(mem_data_valid_i), .mem_data_is_instr_i(mem_data_is_instr_i),
    .mem_write_done_i(mem_write_done_i), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction described by owner/kind and captured fields
  bit            m_busy, m_is_wr, m_owner_dc, m_last_dc, m_is_instr;
  logic [AW-1:0] m_addr;
  access_size_t  m_size;
  logic [LW-1:0] m_wdata;
  int            m_wait;
  // Requester models
  bit ic_pend, dc_rd_pend, dc_wr_pend, ic_just_done, dc_just_done;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic zero_inputs();
    ic_rd_req_i = 0; ic_addr_i = '0; ic_access_size_i = SIZE_BYTE;
    dc_rd_req_i = 0; dc_wr_req_i = 0; dc_addr_i = '0; dc_wr_data_i = '0;
    dc_access_size_i = SIZE_BYTE;
    mem_data_valid_i = 0; mem_data_is_instr_i = 0; mem_write_done_i = 0; mem_data_i = '0;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases, returns at posedge+1
  task automatic apply_reset(input string tag);
    rst_i = 1'b0;
    zero_inputs();
    #1;
    check({tag, "_busy"},    LW'(busy_o), '0);
    check({tag, "_rdv"},     LW'(rd_req_valid_o), '0);
    check({tag, "_wrv"},     LW'(wr_req_valid_o), '0);
    check({tag, "_addr"},    LW'(req_address_o), '0);
    check({tag, "_instr"},   LW'(req_is_instr_o), '0);
    check({tag, "_size"},    LW'(req_access_size_o), '0);
    check({tag, "_wdata"},   wr_data_o, '0);
    check({tag, "_err"},     LW'(err_o), '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    m_busy = 0; m_is_wr = 0; m_owner_dc = 0; m_last_dc = 0; m_is_instr = 0;
    m_addr = '0; m_size = SIZE_BYTE; m_wdata = '0; m_wait = 0;
    ic_pend = 0; dc_rd_pend = 0; dc_wr_pend = 0; ic_just_done = 0; dc_just_done = 0;
  endtask

  // One clock cycle of random traffic checked against the model; entered and left at posedge+1
  task automatic cycle_step(input bit allow_new, input bit force_both);
    bit resp, may_ic, may_dc, ic_c, dc_c, pick;
    int r;
    check("busy",      LW'(busy_o), LW'(m_busy));
    check("rd_valid",  LW'(rd_req_valid_o), LW'(m_busy && !m_is_wr));
    check("wr_valid",  LW'(wr_req_valid_o), LW'(m_busy && m_is_wr));
    check("req_addr",  LW'(req_address_o), LW'(m_addr));
    check("req_instr", LW'(req_is_instr_o), LW'(m_is_instr));
    check("req_size",  LW'(req_access_size_o), LW'(m_size));
    check("wr_data",   wr_data_o, m_wdata);
    check("err_clean", LW'(err_o), '0);

    may_ic = allow_new && !ic_pend && !ic_just_done;
    may_dc = allow_new && !dc_rd_pend && !dc_wr_pend && !dc_just_done;
    ic_just_done = 0;
    dc_just_done = 0;
    if (force_both) begin
      ic_pend = 1; dc_rd_pend = 1;
    end else begin
      if (may_ic && $urandom_range(0, 2) == 0) ic_pend = 1;
      if (may_dc) begin
        r = $urandom_range(0, 5);
        if (r == 0 || r == 2) dc_rd_pend = 1;
        if (r == 1 || r == 2) dc_wr_pend = 1;
      end
    end

    // Requests held, but addresses/data/sizes churn every cycle to prove they are latched
    ic_rd_req_i = ic_pend;
    dc_rd_req_i = dc_rd_pend;
    dc_wr_req_i = dc_wr_pend;
    ic_addr_i = $urandom;
    dc_addr_i = $urandom;
    dc_wr_data_i = rand_line();
    ic_access_size_i = access_size_t'($urandom_range(0, 3));
    dc_access_size_i = access_size_t'($urandom_range(0, 3));

    resp = 0;
    mem_data_valid_i = 0; mem_write_done_i = 0; mem_data_is_instr_i = 0;
    mem_data_i = rand_line();
    if (m_busy) begin
      if (m_wait == 0) resp = 1;
      else m_wait--;
    end
    if (resp) begin
      if (m_is_wr) mem_write_done_i = 1;
      else begin
        mem_data_valid_i = 1;
        mem_data_is_instr_i = m_is_instr;
      end
    end
    #1;
    check("ic_valid", LW'(ic_data_valid_o), LW'(resp && !m_is_wr && !m_owner_dc));
    check("dc_valid", LW'(dc_data_valid_o), LW'(resp && !m_is_wr && m_owner_dc));
    check("wr_done",  LW'(dc_wr_done_o), LW'(resp && m_is_wr));
    if (resp && !m_is_wr && !m_owner_dc) check("ic_data", ic_data_o, mem_data_i);
    if (resp && !m_is_wr && m_owner_dc)  check("dc_data", dc_data_o, mem_data_i);

    if (m_busy && resp) begin
      m_busy = 0;
      if (!m_owner_dc) begin
        ic_pend = 0; ic_just_done = 1;
      end else begin
        if (m_is_wr) dc_wr_pend = 0;
        else dc_rd_pend = 0;
        dc_just_done = 1;
      end
    end else if (!m_busy) begin
      ic_c = ic_rd_req_i;
      dc_c = dc_rd_req_i || dc_wr_req_i;
      if (ic_c || dc_c) begin
        pick = dc_c && (!ic_c || !m_last_dc);
        m_last_dc  = pick;
        m_owner_dc = pick;
        m_busy     = 1;
        m_is_wr    = pick && dc_wr_req_i;
        m_addr     = pick ? dc_addr_i : ic_addr_i;
        m_size     = pick ? dc_access_size_i : ic_access_size_i;
        m_is_instr = !pick;
        if (m_is_wr) m_wdata = dc_wr_data_i;
        m_wait = $urandom_range(0, 4);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    zero_inputs();
    @(posedge clk_i);
    apply_reset("rst0");

    // Contended start, then random traffic, then drain with no new requests
    cycle_step(1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) cycle_step(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) cycle_step(1'b0, 1'b0);
    check("drained_idle", LW'(busy_o), '0);

    // Spurious read data while idle: dropped, sticky error, cleared asynchronously by reset
    zero_inputs();
    mem_data_valid_i = 1;
    mem_data_i = rand_line();
    #1;
    check("spur_ic_valid", LW'(ic_data_valid_o), '0);
    check("spur_dc_valid", LW'(dc_data_valid_o), '0);
    @(posedge clk_i); #1;
    mem_data_valid_i = 0;
    check("spur_err", LW'(err_o), 1);
    check("spur_busy", LW'(busy_o), '0);
    @(posedge clk_i); #1;
    check("spur_err_sticky", LW'(err_o), 1);
    apply_reset("rst1");

    // Reset during a dcache read; a late response afterwards is a protocol error
    dc_rd_req_i = 1;
    dc_addr_i = 32'h100;
    @(posedge clk_i); #1;
    check("dcrd_rdv", LW'(rd_req_valid_o), 1);
    check("dcrd_addr", LW'(req_address_o), LW'(32'h100));
    check("dcrd_instr", LW'(req_is_instr_o), '0);
    apply_reset("rst2");
    mem_data_valid_i = 1;
    #1;
    check("late_dc_valid", LW'(dc_data_valid_o), '0);
    @(posedge clk_i); #1;
    mem_data_valid_i = 0;
    check("late_err", LW'(err_o), 1);
    apply_reset("rst3");

    // Write-done during a read is ignored and held; the real data then completes it
    dc_rd_req_i = 1;
    dc_addr_i = 32'h80;
    @(posedge clk_i); #1;
    dc_addr_i = 32'hC0;
    mem_write_done_i = 1;
    #1;
    check("wrong_done_fwd", LW'(dc_wr_done_o), '0);
    @(posedge clk_i); #1;
    mem_write_done_i = 0;
    check("wrong_done_hold", LW'(busy_o), 1);
    check("wrong_done_err", LW'(err_o), 1);
    check("midchg_addr", LW'(req_address_o), LW'(32'h80));
    mem_data_valid_i = 1;
    mem_data_i = {16{8'h5A}};
    #1;
    check("held_dc_valid", LW'(dc_data_valid_o), 1);
    check("held_dc_data", dc_data_o, {16{8'h5A}});
    @(posedge clk_i); #1;
    zero_inputs();
    check("held_done_idle", LW'(busy_o), '0);
    apply_reset("rst4");

    // Instruction fill answered with a data tag: still delivered, but flagged
    ic_rd_req_i = 1;
    ic_addr_i = 32'h40;
    @(posedge clk_i); #1;
    check("ic_instr", LW'(req_is_instr_o), 1);
    check("ic_addr", LW'(req_address_o), LW'(32'h40));
    mem_data_valid_i = 1;
    mem_data_is_instr_i = 0;
    mem_data_i = {16{8'hA5}};
    #1;
    check("tag_ic_valid", LW'(ic_data_valid_o), 1);
    check("tag_ic_data", ic_data_o, {16{8'hA5}});
    check("tag_dc_valid", LW'(dc_data_valid_o), '0);
    @(posedge clk_i); #1;
    zero_inputs();
    check("tag_err", LW'(err_o), 1);
    check("tag_idle", LW'(busy_o), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the instruction-cache fill port and the data-cache fill/write-back port onto the single shared memory request port. It sits between the CPU's two caches and `mem`. It latches one request at a time, drives it on the memory port until the memory responds, and routes the response back to the cache that issued it. Arbitration is round-robin between the caches, so neither cache can starve the other.

## Interface
Parameters:
- `ADDR_WIDTH`, default `params_pkg::ADDR_WIDTH`: request address width.
- `LINE_WIDTH`, default `CACHE_LINE_BYTES*8`: width of the memory data bus.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `ic_rd_req_i`  in  1  icache line-fill request, level, held until `ic_data_valid_o`.
- `ic_addr_i`  in  ADDR_WIDTH  icache fill address.
- `ic_access_size_i`  in  access_size_t  icache access size.
- `ic_data_valid_o`  out  1  icache fill data valid, one cycle.
- `ic_data_o`  out  LINE_WIDTH  icache fill data.
- `dc_rd_req_i`  in  1  dcache fill request, level.
- `dc_wr_req_i`  in  1  dcache write-back request, level.
- `dc_addr_i`  in  ADDR_WIDTH  dcache address.
- `dc_wr_data_i`  in  LINE_WIDTH  dcache write data.
- `dc_access_size_i`  in  access_size_t  dcache access size.
- `dc_data_valid_o`  out  1  dcache fill data valid, one cycle.
- `dc_data_o`  out  LINE_WIDTH  dcache fill data.
- `dc_wr_done_o`  out  1  dcache write complete, one cycle.
- `rd_req_valid_o`, `wr_req_valid_o`  out  1 each  to memory.
- `req_is_instr_o`  out  1  to memory.
- `req_address_o`  out  ADDR_WIDTH  to memory.
- `wr_data_o`  out  LINE_WIDTH  to memory.
- `req_access_size_o`  out  access_size_t  to memory.
- `mem_data_valid_i`, `mem_data_is_instr_i`, `mem_write_done_i`  in  1 each  from memory.
- `mem_data_i`  in  LINE_WIDTH  from memory.
- `busy_o`  out  1  a transaction is in flight.
- `err_o`  out  1  sticky protocol-error flag.

## Operation
FSM states are `ARB_IDLE`, `ARB_IC_RD`, `ARB_DC_RD`, `ARB_DC_WR`.

Candidate selection in `ARB_IDLE`:
- The dcache candidate is write if `dc_wr_req_i` is high, else read if `dc_rd_req_i` is high. Write-back wins over fill when both dcache requests are high.
- If both the icache and the dcache have a candidate, the grant goes to the cache that is not `last_grant`.
- `last_grant` resets to IC, so the first contended grant goes to the dcache.

On a grant:
- Capture address, access size, write data (dcache writes only) and `req_is_instr` (1 for IC) into registers.
- Update `last_grant` and move to the matching state.
- All memory-side outputs come from these registers and are stable for the whole transaction.
- `rd_req_valid_o` is high in `ARB_IC_RD` and `ARB_DC_RD`. `wr_req_valid_o` is high in `ARB_DC_WR`.

Completion:
- In a read state, the cycle `mem_data_valid_i` is high completes the transaction. `mem_data_i` and a valid pulse go to the owner combinationally (`ic_data_valid_o = mem_data_valid_i & state==ARB_IC_RD`). The non-owner valid stays 0. The FSM returns to `ARB_IDLE` at the next edge.
- In `ARB_DC_WR`, `mem_write_done_i` completes the transaction and is forwarded as `dc_wr_done_o`.
- `ic_data_o` and `dc_data_o` always carry `mem_data_i`; they are only meaningful while the matching valid is high.

Protocol errors set `err_o`, which stays set until reset:
- `mem_data_valid_i` or `mem_write_done_i` high in `ARB_IDLE`. The response is dropped.
- `mem_data_is_instr_i` differing from the registered `req_is_instr` on a read completion. Data is still delivered to the owner.
- `mem_write_done_i` in a read state, or `mem_data_valid_i` in `ARB_DC_WR`. The response is ignored and the state is held.

Requesters must drop their request in the cycle after their valid/done pulse.

## Timing
- Reset (async assert): state `ARB_IDLE` and `last_grant` = IC. All outputs are 0: valids, done, `busy_o`, `err_o`, and the address, data, size and `req_is_instr` registers. Any in-flight response is discarded.
- Latency: a request sampled high at edge N drives the memory request from N+1. The response is forwarded in the same cycle it arrives (zero added latency).
- Completion at cycle k → `ARB_IDLE` during k+1 → next grant at edge k+2. There is one dead cycle minimum between transactions.
- `busy_o` = (state != `ARB_IDLE`).
- Requests arriving while busy are not lost; they are held by the requester and arbitrated on return to `ARB_IDLE`.
- Request inputs changing mid-transaction have no effect on the memory outputs.

## Structure
- Add `arb_state_t` (2-bit enum of the four states) and `arb_owner_t` {`ARB_OWNER_IC`, `ARB_OWNER_DC`} to `params_pkg`, next to the existing `access_size_t`, `ADDR_WIDTH` and `CACHE_LINE_BYTES`.
- A single module with no sub-modules. The round-robin pick is a small combinational block inside it.
- The CPU top instantiates it between the caches and the existing memory port signals.

## Test plan
- IC-only: `ic_rd_req_i`=1, addr 0x40; memory responds after 5 cycles with 0xA5.. → `rd_req_valid_o`=1 and `req_is_instr_o`=1 from edge+1. `ic_data_valid_o` pulses one cycle with the data, and `dc_data_valid_o` stays 0.
- Contention: IC and DC read both asserted from reset → DC (addr 0x100) is granted first, IC (0x0) after the first completion plus one idle cycle. Holding both high alternates DC, IC, DC, IC.
- DC write plus read simultaneous, addr 0x200, data 0xDEADBEEF.. → `wr_req_valid_o`=1 first, `dc_wr_done_o` forwarded, then the read is granted.
- Mid-transaction input change: `dc_addr_i` changed from 0x80 to 0xC0 while busy → `req_address_o` stays 0x80 until completion.
- Spurious `mem_data_valid_i` in `ARB_IDLE` → no valid forwarded and `err_o`=1 sticky. A later `rst_i`=0 clears it asynchronously.
- Reset asserted during `ARB_DC_RD` → all outputs are 0 immediately. A late `mem_data_valid_i` after release is not forwarded and sets `err_o`.
